// File: rtl/port_bus_master.sv
// Fixed-sequence port-bus initiator: acks the responder interrupt, reads four status ports,
// writes one MotCtl command and publishes an atomic snapshot. Optional macro: PBM_WR_SKIP_EN.
module port_bus_master #(
  parameter logic [7:0] RD_PORT0 = 8'h0A,
  parameter logic [7:0] RD_PORT1 = 8'h0B,
  parameter logic [7:0] RD_PORT2 = 8'h0C,
  parameter logic [7:0] RD_PORT3 = 8'h0D,
  parameter logic [7:0] WR_PORT  = 8'h09
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       interrupt,
  output logic       interrupt_ack,
  output logic [7:0] port_id,
  output logic [7:0] out_port,
  input  logic [7:0] in_port,
  output logic       write_strobe,
  output logic       k_write_strobe,
  output logic       read_strobe,
  input  logic [7:0] cmd_in,
  output logic [7:0] snap_locx,
  output logic [7:0] snap_locy,
  output logic [7:0] snap_botinfo,
  output logic [7:0] snap_sensors,
  output logic       snap_valid,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_RD_SETUP, S_RD_STROBE, S_WR_SETUP, S_WR_STROBE, S_DONE
  } state_t;

  state_t          state, state_nx;
  logic [1:0]      idx;
  logic [7:0]      cmd_q;
  logic [3:0][7:0] shadow;
  logic            pending;
  logic            int_prev;
  logic            skip_wr;
  logic            watch;
  logic [7:0]      rd_port;

`ifdef PBM_WR_SKIP_EN
  logic [7:0] last_cmd;
  logic       last_valid;

  assign skip_wr = last_valid && (cmd_q == last_cmd);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_cmd   <= '0;
      last_valid <= 1'b0;
    end else if (state == S_WR_STROBE) begin
      last_cmd   <= cmd_q;
      last_valid <= 1'b1;
    end
  end
`else
  assign skip_wr = 1'b0;
`endif

  always_comb begin
    case (idx)
      2'd0:    rd_port = RD_PORT0;
      2'd1:    rd_port = RD_PORT1;
      2'd2:    rd_port = RD_PORT2;
      default: rd_port = RD_PORT3;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (interrupt) state_nx = S_ACK;
      S_ACK:       state_nx = S_RD_SETUP;
      S_RD_SETUP:  state_nx = S_RD_STROBE;
      S_RD_STROBE: begin
        if (idx == 2'd3) state_nx = skip_wr ? S_DONE : S_WR_SETUP;
        else             state_nx = S_RD_SETUP;
      end
      S_WR_SETUP:  state_nx = S_WR_STROBE;
      S_WR_STROBE: state_nx = S_DONE;
      S_DONE:      state_nx = (pending || interrupt) ? S_ACK : S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    port_id        = '0;
    interrupt_ack  = 1'b0;
    read_strobe    = 1'b0;
    write_strobe   = 1'b0;
    k_write_strobe = 1'b0;
    snap_valid     = 1'b0;
    busy           = (state != S_IDLE);
    case (state)
      S_ACK:       interrupt_ack = 1'b1;
      S_RD_SETUP:  port_id = rd_port;
      S_RD_STROBE: begin
        port_id     = rd_port;
        read_strobe = 1'b1;
      end
      S_WR_SETUP:  port_id = WR_PORT;
      S_WR_STROBE: begin
        port_id      = WR_PORT;
        write_strobe = 1'b1;
      end
      S_DONE:      snap_valid = 1'b1;
      default:     ;
    endcase
  end

  // The responder may still hold interrupt during ACK and the first read setup; ignore it there.
  assign watch = busy && (state != S_ACK) && !((state == S_RD_SETUP) && (idx == 2'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      idx          <= '0;
      cmd_q        <= '0;
      out_port     <= '0;
      shadow       <= '0;
      pending      <= 1'b0;
      overrun      <= 1'b0;
      int_prev     <= 1'b0;
      snap_locx    <= '0;
      snap_locy    <= '0;
      snap_botinfo <= '0;
      snap_sensors <= '0;
    end else begin
      state    <= state_nx;
      int_prev <= interrupt;
      if (state_nx == S_ACK) begin
        cmd_q <= cmd_in;
        idx   <= '0;
      end else if ((state == S_RD_STROBE) && (state_nx == S_RD_SETUP)) begin
        idx <= idx + 2'd1;
      end
      if (state == S_RD_STROBE) shadow[idx] <= in_port;
      if (state_nx == S_WR_SETUP) out_port <= cmd_q;
      // Byte 3 lands on the same edge as the commit when the write phase is skipped.
      if (state_nx == S_DONE) begin
        snap_locx    <= shadow[0];
        snap_locy    <= shadow[1];
        snap_botinfo <= shadow[2];
        snap_sensors <= (state == S_RD_STROBE) ? in_port : shadow[3];
      end
      if (state == S_DONE)             pending <= 1'b0;
      else if (watch && interrupt)     pending <= 1'b1;
      if (watch && interrupt && !int_prev && pending) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_port_bus_master.sv
// Directed bench for port_bus_master: cycle table for one transaction plus sequences for
// command sampling, pending/overrun, mid-transaction reset and the optional write skip.
module tb_port_bus_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       interrupt = 1'b0;
  logic       interrupt_ack;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       write_strobe;
  logic       k_write_strobe;
  logic       read_strobe;
  logic [7:0] cmd_in = 8'h00;
  logic [7:0] snap_locx, snap_locy, snap_botinfo, snap_sensors;
  logic       snap_valid;
  logic       busy;
  logic       overrun;

  logic [7:0] pid_q = 8'h00;
  logic [7:0] salt  = 8'h00;
  int checks = 0;
  int errors = 0;

  port_bus_master dut (
    .clk(clk), .rst(rst), .interrupt(interrupt), .interrupt_ack(interrupt_ack),
    .port_id(port_id), .out_port(out_port), .in_port(in_port),
    .write_strobe(write_strobe), .k_write_strobe(k_write_strobe), .read_strobe(read_strobe),
    .cmd_in(cmd_in), .snap_locx(snap_locx), .snap_locy(snap_locy),
    .snap_botinfo(snap_botinfo), .snap_sensors(snap_sensors),
    .snap_valid(snap_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Responder model: registered read data, one cycle behind port_id.
  always @(posedge clk) pid_q <= port_id;
  always_comb begin
    case (pid_q)
      8'h0A:   in_port = 8'h12 ^ salt;
      8'h0B:   in_port = 8'h34 ^ salt;
      8'h0C:   in_port = 8'h05 ^ salt;
      8'h0D:   in_port = 8'h0F ^ salt;
      default: in_port = 8'hEE;
    endcase
  end

  typedef struct packed {
    logic       ack, rd, wr, bsy, sv;
    logic [7:0] pid, op;
  } row_t;
  row_t tbl [1:13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    interrupt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Raise interrupt before edge 0, then run ncyc cycles; imask bit c is interrupt during cycle c.
  task automatic txn(input logic [7:0] cmd0, input logic [31:0] imask, input int chg_c,
                     input logic [7:0] chg_v, input int ncyc,
                     output logic [31:0] ack_m, output logic [31:0] wr_m,
                     output logic [31:0] sv_m, output int busy_cnt, output logic [7:0] wr_data);
    ack_m = '0; wr_m = '0; sv_m = '0; busy_cnt = 0; wr_data = 8'hXX;
    interrupt = 1'b1;
    cmd_in = cmd0;
    tick();
    for (int c = 1; c <= ncyc; c++) begin
      ack_m[c] = interrupt_ack;
      wr_m[c]  = write_strobe;
      sv_m[c]  = snap_valid;
      if (busy) busy_cnt++;
      if (write_strobe) wr_data = out_port;
      interrupt = imask[c];
      if (c == chg_c) cmd_in = chg_v;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] ack_m, wr_m, sv_m;
    int          bc;
    logic [7:0]  wd;

    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0A, 8'h00};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0A, 8'h00};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0B, 8'h00};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0B, 8'h00};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0C, 8'h00};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0C, 8'h00};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0D, 8'h00};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0D, 8'h00};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h09, 8'h33};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h09, 8'h33};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h33};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h33};

    // Reset state
    tick();
    tick();
    chk("reset ctl", {interrupt_ack, read_strobe, write_strobe, k_write_strobe, busy, snap_valid, overrun}, 7'b0);
    chk("reset bus", {port_id, out_port}, 16'h0000);
    chk("reset snap", {snap_locx, snap_locy, snap_botinfo, snap_sensors}, 32'h0);
    rst = 1'b0;
    tick();

    // Test 1: full transaction against the cycle table
    interrupt = 1'b1;
    cmd_in = 8'h33;
    tick();
    for (int c = 1; c <= 13; c++) begin
      chk($sformatf("t1 cycle %0d", c),
          {interrupt_ack, read_strobe, write_strobe, busy, snap_valid, port_id, out_port}, tbl[c]);
      interrupt = (c < 2);
      tick();
    end
    chk("t1 snap", {snap_locx, snap_locy, snap_botinfo, snap_sensors}, 32'h1234050F);
    chk("t1 kws", k_write_strobe, 1'b0);

    // Test 2: cmd_in change mid-transaction does not affect written byte
    do_reset();
    txn(8'h33, 32'h2, 4, 8'hFF, 13, ack_m, wr_m, sv_m, bc, wd);
    chk("t2 wr data", wd, 8'h33);
    chk("t2 wr cycle", wr_m, 32'h1 << 11);
    txn(8'hFF, 32'h2, 0, 8'h00, 13, ack_m, wr_m, sv_m, bc, wd);
    chk("t2 next wr data", wd, 8'hFF);

    // Test 3: held re-request at cycle 6 -> pending, ACK right after DONE, no overrun
    do_reset();
    txn(8'h21, 32'h3FC2, 10, 8'h22, 25, ack_m, wr_m, sv_m, bc, wd);
    chk("t3 ack cycles", ack_m, (32'h1 << 1) | (32'h1 << 13));
    chk("t3 sv cycles", sv_m, (32'h1 << 12) | (32'h1 << 24));
    chk("t3 wr cycles", wr_m, (32'h1 << 11) | (32'h1 << 23));
    chk("t3 busy cycles", bc, 24);
    chk("t3 second cmd", wd, 8'h22);
    chk("t3 overrun", overrun, 1'b0);

    // Test 4: two pulses in one transaction -> sticky overrun until reset
    do_reset();
    txn(8'h31, 32'h142, 10, 8'h32, 25, ack_m, wr_m, sv_m, bc, wd);
    chk("t4 ack cycles", ack_m, (32'h1 << 1) | (32'h1 << 13));
    chk("t4 overrun set", overrun, 1'b1);
    tick();
    tick();
    chk("t4 overrun sticky", overrun, 1'b1);
    do_reset();
    chk("t4 overrun cleared", overrun, 1'b0);

    // Test 5: reset during the reads
    txn(8'h5A, 32'h2, 0, 8'h00, 13, ack_m, wr_m, sv_m, bc, wd);
    chk("t5 pre snap", {snap_locx, snap_locy, snap_botinfo, snap_sensors}, 32'h1234050F);
    chk("t5 pre out_port", out_port, 8'h5A);
    interrupt = 1'b1;
    cmd_in = 8'h66;
    tick();
    for (int c = 1; c <= 7; c++) begin
      interrupt = (c < 2);
      if (c == 7) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    chk("t5 ctl after rst", {interrupt_ack, read_strobe, write_strobe, busy, snap_valid, overrun}, 6'b0);
    chk("t5 bus after rst", {port_id, out_port}, 16'h0000);
    chk("t5 snap after rst", {snap_locx, snap_locy, snap_botinfo, snap_sensors}, 32'h0);
    tick();
    chk("t5 no late sv", {snap_valid, busy}, 2'b00);
    salt = 8'h80;
    txn(8'h77, 32'h2, 0, 8'h00, 13, ack_m, wr_m, sv_m, bc, wd);
    chk("t5 fresh wr", wd, 8'h77);
    chk("t5 fresh sv", sv_m, 32'h1 << 12);
    chk("t5 fresh snap", {snap_locx, snap_locy, snap_botinfo, snap_sensors}, 32'h92B4858F);
    salt = 8'h00;

    // Test 6: repeated command
    do_reset();
    txn(8'h44, 32'h2, 0, 8'h00, 13, ack_m, wr_m, sv_m, bc, wd);
    chk("t6 first busy", bc, 12);
    chk("t6 first wr", {wr_m, wd}, {32'h1 << 11, 8'h44});
    txn(8'h44, 32'h2, 0, 8'h00, 13, ack_m, wr_m, sv_m, bc, wd);
`ifdef PBM_WR_SKIP_EN
    chk("t6 skip busy", bc, 10);
    chk("t6 skip wr", wr_m, 32'h0);
    chk("t6 skip sv", sv_m, 32'h1 << 10);
    chk("t6 skip snap", {snap_locx, snap_locy, snap_botinfo, snap_sensors}, 32'h1234050F);
`else
    chk("t6 repeat busy", bc, 12);
    chk("t6 repeat wr", {wr_m, wd}, {32'h1 << 11, 8'h44});
`endif
    txn(8'h45, 32'h2, 0, 8'h00, 13, ack_m, wr_m, sv_m, bc, wd);
    chk("t6 changed wr", {wr_m, wd}, {32'h1 << 11, 8'h45});
    chk("t6 changed busy", bc, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/port_bus_master.md
Name: port_bus_master

Overview:
- Hardware initiator for the 8-bit PicoBlaze-style port bus; it is the master-side counterpart of the bot I/O responder.
- It services the responder's Interrupt: acknowledges it, reads four bot status ports, and writes one motor-control command.
- It publishes an atomic snapshot of the four status bytes.
- Used where a fixed polling sequence replaces the soft CPU, e.g. bring-up and autonomous-mode builds.

Parameters:
RD_PORT0, 8'h0A, port read into snap_locx
RD_PORT1, 8'h0B, port read into snap_locy
RD_PORT2, 8'h0C, port read into snap_botinfo
RD_PORT3, 8'h0D, port read into snap_sensors
WR_PORT, 8'h09, port written with cmd_in (MotCtl)

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  synchronous active-high reset
interrupt  in  1  level request from responder; held until acknowledged
interrupt_ack  out  1  one-cycle acknowledge pulse
port_id  out  8  port address
out_port  out  8  write data
in_port  in  8  read data from responder (registered by responder, 1-cycle latency)
write_strobe  out  1  write qualifier
k_write_strobe  out  1  constant-write qualifier; tied 0 by this block
read_strobe  out  1  read qualifier
cmd_in  in  8  MotCtl value to write; sampled at transaction start
snap_locx, snap_locy, snap_botinfo, snap_sensors  out  8 each  snapshot registers
snap_valid  out  1  one-cycle pulse when the snapshot updates
busy  out  1  high from the ACK cycle through the DONE cycle
overrun  out  1  sticky; a new request arrived while busy

Behaviour:
Clock and reset:
- Single clock; all state in clk domain.
- rst is synchronous and active-high.
- On rst, and on the cycle after rst is asserted mid-transaction, all outputs are 0: port_id, out_port, strobes, ack, snapshots, snap_valid, busy, overrun. State returns to IDLE, pending is cleared, and no partial snapshot is committed.

State machine: IDLE -> ACK -> RD_SETUP -> RD_STROBE (x4, index 0..3) -> WR_SETUP -> WR_STROBE -> DONE -> IDLE (or ACK if pending).
- IDLE: if interrupt=1, go to ACK. cmd_in is captured into cmd_q on this edge.
- ACK: interrupt_ack=1 for exactly one cycle. busy=1.
- RD_SETUP: port_id=RD_PORTn; read_strobe=0.
- RD_STROBE: port_id held at RD_PORTn; read_strobe=1. in_port is captured into shadow[n] on the rising edge that ends this cycle.
- After index 3, go to WR_SETUP; otherwise n+1 and RD_SETUP.
- WR_SETUP: port_id=WR_PORT, out_port=cmd_q, strobes 0.
- WR_STROBE: same values; write_strobe=1 for one cycle.
- DONE: all four shadow bytes are copied to snap_* simultaneously; snap_valid=1 for one cycle.

Timing and bus rules:
- Latency: interrupt sampled high at edge 0. ACK is cycle 1, reads occupy cycles 2-9, write cycles 10-11, DONE cycle 12. Total 12 cycles busy.
- port_id is stable for both cycles of every access.
- Strobes are mutually exclusive and never high for 2 consecutive cycles.
- out_port keeps its last value outside writes. port_id returns to 8'h00 in IDLE.

Pending and overrun:
- The responder drops interrupt within 1 cycle after ack. interrupt is ignored during ACK and the following cycle.
- interrupt=1 seen in any later busy cycle sets pending.
- In DONE with pending=1, go directly to ACK, clear pending, and capture cmd_in.
- interrupt=1 while pending=1 already set (second request during one transaction) sets overrun. overrun is cleared only by rst.
- interrupt held high across DONE with no pending is treated as a new request; the next state is ACK.

Snapshot and command rules:
- Snapshot values are only ever from one complete transaction.
- cmd_in changes during a transaction do not affect the byte written.

Optional Feature:
PBM_WR_SKIP_EN:
- Defined: the block keeps last_cmd (reset 8'h00, with a valid bit reset to 0). If cmd_q equals last_cmd and the valid bit is set, WR_SETUP and WR_STROBE are skipped: RD_STROBE index 3 goes straight to DONE, 10 cycles busy. Otherwise the write is performed and last_cmd and the valid bit are updated.
- Not defined: the write is always performed (12 cycles). No last_cmd register exists.

Test Plan:
1. rst, then interrupt=1 at edge 0 with cmd_in=8'h33; responder returns 8'h12/8'h34/8'h05/8'h0F. Required: interrupt_ack at cycle 1; read_strobe at cycles 3,5,7,9 with port_id 0A,0B,0C,0D; write_strobe at cycle 11 with port_id=09 and out_port=33; snap_valid at cycle 12; snap_*=12,34,05,0F.
2. cmd_in changed to 8'hFF at cycle 4 of a transaction. Required: 8'h33 written; the next transaction writes FF.
3. interrupt reasserted at cycle 6. Required: pending; ACK follows DONE directly (cycle 13); overrun stays 0.
4. interrupt pulsed at cycle 6 and again at cycle 8. Required: overrun=1 and stays 1 until rst.
5. rst asserted at cycle 7 mid-read. Required: next cycle all strobes 0, busy 0, snap_*=00, no snap_valid; a fresh interrupt runs normally.
6. PBM_WR_SKIP_EN defined, two transactions with cmd_in=8'h44. Required: first writes 44 (busy 12 cycles); second has no write_strobe, DONE at cycle 10.
